// File: rtl/sram_lsu_bridge.sv
// Load/store bridge from the core LSU to the 32-bit SRAM controller.
// It accepts one request at a time, builds the lane mask and replicated
// store data, and holds the strobe until ACK. It then extends load data.
// Illegal or misaligned requests and ACK timeouts end in a one-cycle error pulse.
module sram_lsu_bridge #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_lsu_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [17:0] o_ADDR,
  output logic [31:0] o_WDATA,
  output logic [3:0]  o_BMASK,
  output logic        o_WREN,
  output logic        o_RDEN,
  input  logic [31:0] i_RDATA,
  input  logic        i_ACK
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  // Last REQ cycle index; the counter starts at 0 on REQ entry.
  localparam logic [7:0] C_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic        r_we;
  logic        r_to;
  logic [31:0] r_rdata;
  logic [17:0] r_ADDR;
  logic [31:0] r_WDATA;
  logic [3:0]  r_BMASK;
  logic        r_WREN, r_RDEN;

  logic        w_req, w_illegal, w_mis, w_expire;
  logic [1:0]  w_size;
  logic [3:0]  w_bmask;
  logic [31:0] w_wdata, w_shift, w_ext;
  logic        w_unused_addr;

  // Select the addressed lane and apply sign or zero extension.
  function automatic logic [31:0] f_extend(input logic [2:0] f3,
                                           input logic [31:0] sh);
    logic [31:0] v;
    case (f3)
      3'b000:  v = {{24{sh[7]}}, sh[7:0]};
      3'b001:  v = {{16{sh[15]}}, sh[15:0]};
      3'b100:  v = {24'd0, sh[7:0]};
      3'b101:  v = {16'd0, sh[15:0]};
      default: v = sh;
    endcase
    return v;
  endfunction

  assign w_unused_addr = ^i_lsu_addr[31:18];
  assign w_req    = i_lsu_wren | i_lsu_rden;
  assign w_size   = i_funct3[1:0];
  assign w_expire = (r_cnt == C_LAST);
  // A halfword lane is 16 bits, so only lane[1] matters for the shift.
  assign w_shift  = (r_f3[1:0] == 2'b00) ? (i_RDATA >> {r_lane, 3'b000}) :
                    (i_RDATA >> {r_lane[1], 4'b0000});
  assign w_ext    = f_extend(r_f3, w_shift);

  // Decode the incoming request: legality, alignment, lane mask, store data.
  always_comb begin
    w_illegal = i_lsu_wren ? (i_funct3 > 3'b010)
                           : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
    w_mis     = ((w_size == 2'b01) && i_lsu_addr[0]) ||
                ((w_size == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
    case (w_size)
      2'b00: begin
        w_bmask = 4'b0001 << i_lsu_addr[1:0];
        w_wdata = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        w_bmask = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_lsu_wdata[15:0]}};
      end
      default: begin
        w_bmask = 4'b1111;
        w_wdata = i_lsu_wdata;
      end
    endcase
  end

  // Next-state logic: ACK beats an expiring timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (w_illegal || w_mis) ? S_ERR : S_REQ;
      S_REQ: begin
        if (i_ACK)         w_next = S_DONE;
        else if (w_expire) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, request capture, registered controller strobes and load data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_f3    <= 3'd0;
      r_lane  <= 2'd0;
      r_we    <= 1'b0;
      r_to    <= 1'b0;
      r_rdata <= 32'd0;
      r_ADDR  <= 18'd0;
      r_WDATA <= 32'd0;
      r_BMASK <= 4'd0;
      r_WREN  <= 1'b0;
      r_RDEN  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_f3    <= i_funct3;
          r_lane  <= i_lsu_addr[1:0];
          r_we    <= i_lsu_wren;
          r_to    <= 1'b0;
          r_cnt   <= 8'd0;
          r_ADDR  <= {i_lsu_addr[17:2], 2'b00};
          r_WDATA <= w_wdata;
          r_BMASK <= w_bmask;
          if (w_next == S_REQ) begin
            r_WREN <= i_lsu_wren;
            r_RDEN <= ~i_lsu_wren;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_next != S_REQ) begin
            r_WREN <= 1'b0;
            r_RDEN <= 1'b0;
          end
          if (i_ACK && !r_we) r_rdata <= w_ext;
          if (w_next == S_ERR) r_to <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_stall      = ~i_reset & w_req & ((r_state == S_IDLE) || (r_state == S_REQ));
  assign o_misaligned = (r_state == S_ERR) & ~r_to;
  assign o_timeout    = (r_state == S_ERR) & r_to;
  assign o_lsu_rdata  = r_rdata;
  assign o_ADDR       = r_ADDR;
  assign o_WDATA      = r_WDATA;
  assign o_BMASK      = r_BMASK;
  assign o_WREN       = r_WREN;
  assign o_RDEN       = r_RDEN;

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Scoreboard bench for sram_lsu_bridge: the driver queues the expected
// outcome, a monitor checks each completion, and a responder models the
// controller ACK with a per-transaction delay.
module tb_sram_lsu_bridge;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_lsu_addr = '0, i_lsu_wdata = '0, i_RDATA = '0;
  logic        i_lsu_wren = 1'b0, i_lsu_rden = 1'b0, i_ACK = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] o_lsu_rdata, o_WDATA;
  logic        o_stall, o_misaligned, o_timeout, o_WREN, o_RDEN;
  logic [17:0] o_ADDR;
  logic [3:0]  o_BMASK;

  always #5 clk = ~clk;

  sram_lsu_bridge #(.ACK_TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_wren(i_lsu_wren), .i_lsu_rden(i_lsu_rden),
    .i_funct3(i_funct3), .o_lsu_rdata(o_lsu_rdata), .o_stall(o_stall),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout), .o_ADDR(o_ADDR),
    .o_WDATA(o_WDATA), .o_BMASK(o_BMASK), .o_WREN(o_WREN), .o_RDEN(o_RDEN),
    .i_RDATA(i_RDATA), .i_ACK(i_ACK)
  );

  // kind: 0 = completes in DONE, 1 = misaligned/illegal, 2 = timeout
  typedef struct {
    int          kind;
    bit          load;
    logic [31:0] rdata;
    int          stall;
    bit          strobe;
    logic [17:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
    bit          we;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   ack_after = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Controller model: raise ACK on the ack_after-th strobe cycle (0 = never).
  int rcnt = 0;
  always @(negedge clk) begin
    if (o_WREN | o_RDEN) begin
      rcnt++;
      i_ACK = (rcnt == ack_after);
    end else begin
      rcnt = 0;
      i_ACK = 1'b0;
    end
  end

  // Monitor: count stall cycles, capture the first strobe cycle and check
  // everything when the stall drops while the request is still held.
  int          m_stall = 0;
  bit          m_seen = 0;
  logic [17:0] m_addr;
  logic [3:0]  m_bmask;
  logic [31:0] m_wdata;
  logic        m_wren;
  exp_t        m_e;
  always @(negedge clk) begin
    if (i_reset || !(i_lsu_wren | i_lsu_rden)) begin
      m_stall = 0;
      m_seen  = 0;
    end else if (o_stall) begin
      m_stall++;
      if ((o_WREN | o_RDEN) && !m_seen) begin
        m_seen  = 1;
        m_addr  = o_ADDR;
        m_bmask = o_BMASK;
        m_wdata = o_WDATA;
        m_wren  = o_WREN;
      end
    end else begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_completion: got completion with empty queue");
      end else begin
        m_e = q.pop_front();
        check("flags{to,mis}", {30'd0, o_timeout, o_misaligned},
              (m_e.kind == 2) ? 32'd2 : (m_e.kind == 1) ? 32'd1 : 32'd0);
        check("stall_cycles", m_stall, m_e.stall);
        check("strobe_seen", {31'd0, m_seen}, {31'd0, m_e.strobe});
        check("strobe_low", {30'd0, o_WREN, o_RDEN}, 32'd0);
        if (m_e.strobe) begin
          check("o_ADDR", {14'd0, m_addr}, {14'd0, m_e.addr});
          check("o_BMASK", {28'd0, m_bmask}, {28'd0, m_e.bmask});
          check("o_WREN_dir", {31'd0, m_wren}, {31'd0, m_e.we});
          if (m_e.we) check("o_WDATA", m_wdata, m_e.wdata);
        end
        if (m_e.kind == 0 && m_e.load) check("o_lsu_rdata", o_lsu_rdata, m_e.rdata);
      end
      m_stall = 0;
      m_seen  = 0;
    end
  end

  task automatic txn(input bit we, input bit re, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int ack, input int kind,
                     input logic [31:0] xr, input int stall,
                     input logic [3:0] bm, input logic [31:0] xwd);
    exp_t e;
    int   k;
    e.kind = kind; e.load = !we; e.rdata = xr; e.stall = stall;
    e.strobe = (kind != 1); e.addr = {addr[17:2], 2'b00};
    e.bmask = bm; e.wdata = xwd; e.we = we;
    q.push_back(e);
    @(posedge clk); #1;
    ack_after = ack; i_RDATA = rd; i_lsu_addr = addr; i_lsu_wdata = wd;
    i_funct3 = f3; i_lsu_wren = we; i_lsu_rden = re;
    k = 0;
    do begin @(negedge clk); k++; end while (o_stall && k < 50);
    if (o_stall) begin
      n_chk++;
      $display("FAIL stall_bound: stall still high after %0d cycles, required low", k);
    end
    #1;
    i_lsu_wren = 1'b0; i_lsu_rden = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_strobes", {30'd0, o_WREN, o_RDEN}, 32'd0);
    check("rst_errs", {30'd0, o_timeout, o_misaligned}, 32'd0);
    check("rst_addr_mask", {10'd0, o_ADDR, o_BMASK}, 32'd0);
    @(posedge clk); #1 i_reset = 1'b0;

    //  we re f3      addr          wdata         rdata         ack kind exp_rdata     stall bmask    exp_wdata
    txn(1, 0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        3, 0, 32'h0,         4, 4'b1111, 32'hDEAD_BEEF);
    txn(1, 0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1, 0, 32'h0,         2, 4'b1000, 32'hA5A5_A5A5);
    txn(1, 0, 3'b001, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        2, 0, 32'h0,         3, 4'b1100, 32'hABCD_ABCD);
    txn(0, 1, 3'b000, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 0, 32'hFFFF_FF80, 2, 4'b0100, 32'h0);
    txn(0, 1, 3'b100, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 0, 32'h0000_0080, 2, 4'b0100, 32'h0);
    txn(0, 1, 3'b101, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 0, 32'h0000_1280, 2, 4'b1100, 32'h0);
    txn(0, 1, 3'b001, 32'h0000_0100, 32'h0,         32'h1280_F456, 2, 0, 32'hFFFF_F456, 3, 4'b0011, 32'h0);
    txn(0, 1, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 2, 4'b1111, 32'h0);
    txn(0, 1, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        1, 1, 32'h0,         1, 4'b0000, 32'h0);
    txn(1, 0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,        1, 1, 32'h0,         1, 4'b0000, 32'h0);
    txn(1, 0, 3'b100, 32'h0000_0100, 32'h0,         32'h0,        1, 1, 32'h0,         1, 4'b0000, 32'h0);
    txn(0, 1, 3'b011, 32'h0000_0100, 32'h0,         32'h0,        1, 1, 32'h0,         1, 4'b0000, 32'h0);
    txn(1, 1, 3'b010, 32'h0000_0108, 32'h1122_3344, 32'h0,        1, 0, 32'h0,         2, 4'b1111, 32'h1122_3344);
    txn(0, 1, 3'b010, 32'h0000_0000, 32'h0,         32'h0,        0, 2, 32'h0,         5, 4'b1111, 32'h0);
    txn(0, 1, 3'b010, 32'h0000_0000, 32'h0,         32'h55AA_55AA, 4, 0, 32'h55AA_55AA, 5, 4'b1111, 32'h0);
    txn(0, 1, 3'b010, 32'hFFFC_0010, 32'h0,         32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D, 2, 4'b1111, 32'h0);

    // Reset in the middle of a transaction stuck in REQ.
    @(posedge clk); #1;
    ack_after = 0; i_lsu_addr = 32'h0000_0200; i_funct3 = 3'b010; i_lsu_rden = 1'b1;
    @(negedge clk); @(negedge clk);
    check("pre_rst_rden", {31'd0, o_RDEN}, 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, o_stall}, 32'd0);
    check("mid_rst_strobes", {30'd0, o_WREN, o_RDEN}, 32'd0);
    check("mid_rst_addr", {14'd0, o_ADDR}, 32'd0);
    check("mid_rst_bmask", {28'd0, o_BMASK}, 32'd0);
    check("mid_rst_wdata", o_WDATA, 32'd0);
    check("mid_rst_rdata", o_lsu_rdata, 32'd0);
    #1 i_lsu_rden = 1'b0;
    @(posedge clk); #1 i_reset = 1'b0;

    txn(0, 1, 3'b100, 32'h0000_0103, 32'h0,         32'h9A00_0000, 1, 0, 32'h0000_009A, 2, 4'b1000, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
